// File: rtl/pe_array_scheduler_pkg.sv
// Shared definitions for the PE array scheduler: FSM encoding, array constants,
// index widths and the layer-configuration validity check.
package pe_array_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_W    = 3'd1,
        ST_COMPUTE   = 3'd2,
        ST_WAIT_PIPE = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam int ARRAY_SIZE_DEF = 16;
    localparam int PIPE_LAT_DEF   = 19;
    localparam int ROW_W          = 4;
    localparam int IDX_W          = 8;
    localparam int KS_W           = 3;
    // Wide enough for ofmap_size + kernel_size - 1 = 261 activation beats.
    localparam int BEAT_W         = 9;

    function automatic logic cfg_valid(input logic [IDX_W-1:0] ofmap,
                                       input logic [IDX_W-1:0] nch,
                                       input logic [KS_W-1:0]  ksz,
                                       input int               array_size);
        return (ofmap != 8'd0) && (nch != 8'd0) && (ksz != 3'd0) &&
               (int'(ksz) <= array_size);
    endfunction

endpackage

// File: rtl/pe_array_scheduler_sched_counter.sv
// Clear/enable up-counter with a terminal-count flag; one instance per
// beat stream (weights, activations, pipe wait, drain).
module sched_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == term);

endmodule

// File: rtl/pe_array_scheduler.sv
// Layer scheduler for a weight-stationary PE array: loads weights per channel,
// streams activations, waits out the array pipeline and drains results.
module pe_array_scheduler
    import pe_array_scheduler_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             operation_mode,
    input  logic [IDX_W-1:0] ofmap_size,
    input  logic [IDX_W-1:0] num_channels,
    input  logic [KS_W-1:0]  kernel_size,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic             act_valid,
    output logic             act_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] weight_row,
    output logic [IDX_W-1:0] channel_idx,
    output logic [IDX_W-1:0] ofmap_idx,
    output logic             start_computation,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             op_mode_out
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ofmap_q, ofmap_d;
    logic [IDX_W-1:0]   num_ch_q, num_ch_d;
    logic [IDX_W-1:0]   ch_idx_q, ch_idx_d;
    logic [KS_W-1:0]    k_q, k_d;
    logic               mode_q, mode_d;
    logic               cfg_err_q, cfg_err_d;

    logic               w_hs, a_hs, o_hs;
    logic               w_tc, a_tc, p_tc, o_tc;
    logic [BEAT_W-1:0]  act_term;
    logic [BEAT_W-1:0]  act_cnt_unused;
    logic [BEAT_W-1:0]  pipe_cnt_unused;

    // Readies depend only on state; reset forces every control output low.
    assign w_ready           = (state_q == ST_LOAD_W)  && !reset;
    assign act_ready         = (state_q == ST_COMPUTE) && !reset;
    assign out_valid         = (state_q == ST_DRAIN)   && !reset;
    assign done              = (state_q == ST_DONE)    && !reset;
    assign busy              = (state_q != ST_IDLE)    && !reset;
    assign w_hs              = w_valid && w_ready;
    assign a_hs              = act_valid && act_ready;
    assign o_hs              = out_valid && out_ready;
    assign start_computation = w_hs && w_tc;
    assign cfg_err           = cfg_err_q;
    assign channel_idx       = ch_idx_q;
    assign op_mode_out       = mode_q;
    assign act_term          = {1'b0, ofmap_q} + {{(BEAT_W-KS_W){1'b0}}, k_q} - 9'd2;

    sched_counter #(.W(ROW_W)) u_w_cnt (
        .clk(clk), .reset(reset), .clr(state_q != ST_LOAD_W), .en(w_hs),
        .term(ROW_W'(ARRAY_SIZE - 1)), .count(weight_row), .tc(w_tc)
    );

    sched_counter #(.W(BEAT_W)) u_act_cnt (
        .clk(clk), .reset(reset), .clr(state_q != ST_COMPUTE), .en(a_hs),
        .term(act_term), .count(act_cnt_unused), .tc(a_tc)
    );

    sched_counter #(.W(BEAT_W)) u_pipe_cnt (
        .clk(clk), .reset(reset), .clr(state_q != ST_WAIT_PIPE), .en(1'b1),
        .term(BEAT_W'(PIPE_LAT - 1)), .count(pipe_cnt_unused), .tc(p_tc)
    );

    sched_counter #(.W(IDX_W)) u_drain_cnt (
        .clk(clk), .reset(reset), .clr(state_q != ST_DRAIN), .en(o_hs),
        .term(ofmap_q - 8'd1), .count(ofmap_idx), .tc(o_tc)
    );

    // Next-state, config latch and channel sequencing.
    always_comb begin
        state_d   = state_q;
        ofmap_d   = ofmap_q;
        num_ch_d  = num_ch_q;
        k_d       = k_q;
        mode_d    = mode_q;
        ch_idx_d  = ch_idx_q;
        cfg_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && cfg_valid(ofmap_size, num_channels, kernel_size, ARRAY_SIZE)) begin
                    ofmap_d  = ofmap_size;
                    num_ch_d = num_channels;
                    k_d      = kernel_size;
                    mode_d   = operation_mode;
                    ch_idx_d = 8'd0;
                    state_d  = ST_LOAD_W;
                end else if (start) begin
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                if (w_hs && w_tc) begin
                    state_d = ST_COMPUTE;
                end else begin
                    state_d = ST_LOAD_W;
                end
            end
            ST_COMPUTE: begin
                if (a_hs && a_tc && (ch_idx_q == num_ch_q - 8'd1)) begin
                    state_d = ST_WAIT_PIPE;
                end else if (a_hs && a_tc) begin
                    ch_idx_d = ch_idx_q + 8'd1;
                    state_d  = ST_LOAD_W;
                end else begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_WAIT_PIPE: begin
                if (p_tc) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT_PIPE;
                end
            end
            ST_DRAIN: begin
                if (o_hs && o_tc) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ofmap_q   <= 8'd0;
            num_ch_q  <= 8'd0;
            k_q       <= 3'd0;
            mode_q    <= 1'b0;
            ch_idx_q  <= 8'd0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ofmap_q   <= ofmap_d;
            num_ch_q  <= num_ch_d;
            k_q       <= k_d;
            mode_q    <= mode_d;
            ch_idx_q  <= ch_idx_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Directed bench for pe_array_scheduler: handshake beat counts, cycle totals,
// backpressure holds, config errors, mid-run reset and the largest layer.
module tb_pe_array_scheduler;

    logic       clk = 1'b0;
    logic       reset, start, operation_mode;
    logic [7:0] ofmap_size, num_channels;
    logic [2:0] kernel_size;
    logic       w_valid, w_ready, act_valid, act_ready, out_valid, out_ready;
    logic [3:0] weight_row;
    logic [7:0] channel_idx, ofmap_idx;
    logic       start_computation, busy, done, cfg_err, op_mode_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_w = 0, cnt_a = 0, cnt_o = 0, cnt_busy = 0, cnt_done = 0;
    int cnt_sc = 0, cnt_err = 0, cnt_gap = 0, max_row = 0, max_ch = 0;
    int b_w, b_a, b_o, b_busy, b_done, b_sc, b_err, b_gap;
    bit w_toggle = 1'b0;
    bit found;

    always #5 clk = ~clk;

    pe_array_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .operation_mode(operation_mode),
        .ofmap_size(ofmap_size), .num_channels(num_channels), .kernel_size(kernel_size),
        .w_valid(w_valid), .w_ready(w_ready), .act_valid(act_valid), .act_ready(act_ready),
        .out_valid(out_valid), .out_ready(out_ready), .weight_row(weight_row),
        .channel_idx(channel_idx), .ofmap_idx(ofmap_idx),
        .start_computation(start_computation), .busy(busy), .done(done),
        .cfg_err(cfg_err), .op_mode_out(op_mode_out)
    );

    // Per-cycle event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (w_valid && w_ready)    cnt_w++;
        if (act_valid && act_ready) cnt_a++;
        if (out_valid && out_ready) cnt_o++;
        if (busy)                  cnt_busy++;
        if (done)                  cnt_done++;
        if (start_computation)     cnt_sc++;
        if (cfg_err)               cnt_err++;
        if (busy && !w_ready && !act_ready && !out_valid && !done) cnt_gap++;
        if (int'(weight_row) > max_row)  max_row = int'(weight_row);
        if (int'(channel_idx) > max_ch)  max_ch  = int'(channel_idx);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (w_toggle) w_valid = ~w_valid;
    endtask

    task automatic snap();
        b_w = cnt_w; b_a = cnt_a; b_o = cnt_o; b_busy = cnt_busy;
        b_done = cnt_done; b_sc = cnt_sc; b_err = cnt_err; b_gap = cnt_gap;
    endtask

    task automatic set_cfg(input int o, input int c, input int k, input bit m);
        ofmap_size = 8'(o); num_channels = 8'(c); kernel_size = 3'(k); operation_mode = m;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_done_seen"}, int'(found), 1);
        repeat (3) tick();
    endtask

    function automatic int ctl_vec();
        return int'({busy, w_ready, act_ready, out_valid, done, cfg_err, start_computation});
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; w_valid = 1'b0; act_valid = 1'b0; out_ready = 1'b0;
        set_cfg(0, 0, 0, 1'b0);

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ctl_during", ctl_vec(), 0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_ctl_after", ctl_vec(), 0);
        chk("rst_idx_after", int'({weight_row, channel_idx, ofmap_idx}), 0);

        // Nominal: ofmap=4, ch=2, k=3, everything ready
        tick();
        w_valid = 1'b1; act_valid = 1'b1; out_ready = 1'b1;
        set_cfg(4, 2, 3, 1'b0);
        snap();
        pulse_start();
        wait_done("nom", 300);
        chk("nom_w_beats",   cnt_w - b_w, 32);
        chk("nom_act_beats", cnt_a - b_a, 12);
        chk("nom_out_beats", cnt_o - b_o, 4);
        chk("nom_busy_cyc",  cnt_busy - b_busy, 68);
        chk("nom_wait_cyc",  cnt_gap - b_gap, 19);
        chk("nom_done_cnt",  cnt_done - b_done, 1);
        chk("nom_startcomp", cnt_sc - b_sc, 2);
        chk("nom_cfg_err",   cnt_err - b_err, 0);
        chk("nom_max_row",   max_row, 15);
        chk("nom_max_ch",    max_ch, 1);
        chk("nom_idle_busy", int'(busy), 0);

        // Backpressure: 50% w_valid, out_ready low 5 cycles mid-drain
        set_cfg(4, 1, 3, 1'b0);
        w_valid = 1'b0; w_toggle = 1'b1;
        snap();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid && ofmap_idx == 8'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("bp_reach_drain", int'(found), 1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_idx", int'(ofmap_idx), 3);
            chk("bp_hold_valid", int'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1; w_toggle = 1'b0; w_valid = 1'b1;
        wait_done("bp", 300);
        chk("bp_w_beats",   cnt_w - b_w, 16);
        chk("bp_act_beats", cnt_a - b_a, 6);
        chk("bp_out_beats", cnt_o - b_o, 4);
        chk("bp_done_cnt",  cnt_done - b_done, 1);

        // Invalid configs: ofmap=0, then kernel_size=0
        set_cfg(0, 1, 3, 1'b0);
        snap();
        pulse_start();
        repeat (4) tick();
        chk("bad_ofmap_err",  cnt_err - b_err, 1);
        chk("bad_ofmap_busy", cnt_busy - b_busy, 0);
        set_cfg(4, 1, 0, 1'b0);
        snap();
        pulse_start();
        repeat (4) tick();
        chk("bad_k_err",  cnt_err - b_err, 1);
        chk("bad_k_busy", cnt_busy - b_busy, 0);

        // Mid-run reset after three activation beats
        set_cfg(4, 1, 3, 1'b0);
        snap();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (act_ready) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mr_reach_compute", int'(found), 1);
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_act_beats", cnt_a - b_a, 3);
        chk("mr_ctl_during", ctl_vec(), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mr_ctl_after", ctl_vec(), 0);
        chk("mr_idx_after", int'({weight_row, channel_idx, ofmap_idx}), 0);
        tick();
        snap();
        pulse_start();
        wait_done("mr_rerun", 300);
        chk("mr_rerun_w",    cnt_w - b_w, 16);
        chk("mr_rerun_act",  cnt_a - b_a, 6);
        chk("mr_rerun_out",  cnt_o - b_o, 4);
        chk("mr_rerun_busy", cnt_busy - b_busy, 46);

        // Start while busy plus config change during LOAD_W
        set_cfg(4, 1, 3, 1'b1);
        snap();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (w_ready) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("sb_reach_load", int'(found), 1);
        tick();
        set_cfg(9, 3, 5, 1'b0);
        pulse_start();
        @(negedge clk);
        chk("sb_mode_held", int'(op_mode_out), 1);
        wait_done("sb", 300);
        chk("sb_out_beats", cnt_o - b_o, 4);
        chk("sb_act_beats", cnt_a - b_a, 6);
        chk("sb_busy_cyc",  cnt_busy - b_busy, 46);
        chk("sb_done_cnt",  cnt_done - b_done, 1);

        // Largest layer: 261 activation beats, 255 results
        set_cfg(255, 1, 7, 1'b0);
        snap();
        pulse_start();
        wait_done("max", 2000);
        chk("max_w_beats",   cnt_w - b_w, 16);
        chk("max_act_beats", cnt_a - b_a, 261);
        chk("max_out_beats", cnt_o - b_o, 255);
        chk("max_busy_cyc",  cnt_busy - b_busy, 552);
        chk("max_done_cnt",  cnt_done - b_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_array_scheduler.md
PE_ARRAY_SCHEDULER -- requirements
Module: pe_array_scheduler

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 16: number of PE rows loaded per weight pass.
REQ-002 SHALL have parameter PIPE_LAT, default 19: cycles from last activation to first valid result (ARRAY_SIZE + reg_op_out + 2 delay stages).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port start, input, 1: request a layer run.
REQ-006 SHALL have port operation_mode, input, 1: 0 = Normal, 1 = Split; latched and forwarded.
REQ-007 SHALL have ports ofmap_size (8), num_channels (8) and kernel_size (3), all inputs: layer configuration.
REQ-008 SHALL have ports w_valid (input, 1) and w_ready (output, 1): weight-buffer handshake.
REQ-009 SHALL have ports act_valid (input, 1) and act_ready (output, 1): activation-stream handshake.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result-drain handshake.
REQ-011 SHALL have outputs weight_row (4), channel_idx (8) and ofmap_idx (8): current indices.
REQ-012 SHALL have output start_computation, 1: one-cycle pulse to the PE array.
REQ-013 SHALL have outputs busy (1), done (1) and cfg_err (1).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD_W, COMPUTE, WAIT_PIPE, DRAIN, DONE.
REQ-015 In IDLE with start=1 and a valid config, SHALL latch the config, clear channel_idx, and enter LOAD_W next cycle.
REQ-016 Valid config SHALL mean ofmap_size≠0, num_channels≠0 and kernel_size in 1..ARRAY_SIZE.
REQ-017 On start with an invalid config, SHALL stay in IDLE and pulse cfg_err for one cycle.
REQ-018 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-019 LOAD_W: w_ready=1; weight_row SHALL increment only on w_valid&w_ready.
REQ-020 LOAD_W SHALL exit to COMPUTE on the accepted beat at weight_row=ARRAY_SIZE-1, with start_computation high in that exit cycle.
REQ-021 COMPUTE: act_ready=1; SHALL accept exactly ofmap_size+kernel_size-1 beats per channel, counting only on act_valid&act_ready.
REQ-022 After the last beat of a channel, SHALL go to LOAD_W if channel_idx<num_channels-1 (channel_idx increments, weight_row clears); otherwise SHALL go to WAIT_PIPE.
REQ-023 WAIT_PIPE SHALL last exactly PIPE_LAT cycles, then enter DRAIN.
REQ-024 DRAIN: out_valid=1; ofmap_idx SHALL increment on out_valid&out_ready.
REQ-025 DRAIN SHALL exit to DONE on the handshake at ofmap_idx=ofmap_size-1.
REQ-026 If out_ready=0, ofmap_idx and state SHALL hold.
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Handshake readies SHALL be combinational decodes of state only; a ready SHALL never depend on its own valid.
REQ-030 Counters SHALL be wide enough that ofmap_size=255, kernel_size=7 (261 beats) is handled without wrap.
REQ-031 Config inputs SHALL be sampled only at start acceptance; changes mid-run SHALL have no effect.

Reset
REQ-032 reset=1 SHALL force IDLE in any state, including mid-run.
REQ-033 reset=1 SHALL clear all counters and latched config.
REQ-034 reset=1 SHALL drive w_ready, act_ready, out_valid, start_computation, busy, done and cfg_err to 0.
REQ-035 Outputs SHALL hold reset values on the first cycle after reset deasserts.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding and the constants ARRAY_SIZE, PIPE_LAT and the index widths.
REQ-037 The beat counter SHALL be a single sub-module, sched_counter (load/enable/terminal-count), instantiated for the weight, activation, pipe-wait and drain counts.

Verification
REQ-038 Nominal run: cfg ofmap=4, ch=2, k=3, all valids/readies 1 -> 16 w beats, 6 act beats, 16 w beats, 6 act beats, 19-cycle wait, 4 out beats, done pulse; total cycles checked.
REQ-039 Backpressure: w_valid toggling 50%, out_ready low for 5 cycles mid-DRAIN -> indices hold, count still exactly 16 and 4.
REQ-040 Invalid config: start with ofmap=0, then with kernel_size=0 -> one cfg_err pulse each, busy stays 0.
REQ-041 Mid-run reset: assert reset in COMPUTE at act beat 3 -> next cycle IDLE, all outputs 0; a new start runs cleanly.
REQ-042 Start while busy and config change mid-run: pulse start and change ofmap_size during LOAD_W -> ignored, drain count equals the latched value.
REQ-043 Max config: ofmap=255, ch=1, k=7 -> exactly 261 act beats and 255 out beats, no wrap.
